blink_rate_ctrl: RTL and testbench
==================================

# blink_rate_ctrl

Rate controller for the LED blink divider. It takes rate commands from the UART receive path and a front-panel button and drives the divider's 2-bit rate select. New rates are applied only on a falling edge of the divider output, so the blink never produces a runt pulse. Optionally, it sweeps automatically through the rates at a fixed interval.

## Interface
Parameters:
- CLOCKFREQ, 100_000_000: iClk frequency in Hz; used only by the auto-sweep timer.
- SWEEP_SEC, 5: auto-sweep interval in seconds. CLOCKFREQ*SWEEP_SEC must be ≤ 2^32.

Ports (one clock; reset is asynchronous and active-low):
- iClk  in  1  system clock, 100 MHz
- iRSt_n  in  1  asynchronous active-low reset
- iRxData  in  8  received UART byte
- iRxValid  in  1  single-cycle strobe; iRxData is valid in that cycle
- iBtnNext  in  1  debounced button level; a rising edge requests the next rate
- iDivClk  in  1  divider blink output, treated as asynchronous
- oRate_control  out  2  rate select to divider: 00=1 Hz, 01=5 Hz, 10=10 Hz; 11 is never driven
- oBusy  out  1  high while a rate change is pending
- oCmdErr  out  1  one-cycle pulse on an unrecognised byte

## Operation
- Byte decode:
  - 0x30 ('0') → 00
  - 0x31 ('1') → 01
  - 0x32 ('2') → 10
  - 0x6E ('n') → next rate
  - 0x61 ('a') → sweep toggle; see Configuration
  - any other byte → oCmdErr pulses high in the cycle after iRxValid, with no other effect
- Next-rate sequence: 00→01→10→00. "Next" is computed from the pending target if one exists, otherwise from oRate_control.
- Button: iBtnNext is registered once. A rising edge (current=1, previous=0) raises a next request.
- Request priority in one cycle: UART > button > sweep tick. Lower-priority requests in that cycle are dropped, not queued.
- iDivClk passes through a 3-flop chain s1→s2→s3. A falling edge is detected when s3=1 and s2=0.
- FSM states:
  - IDLE: on a request whose target ≠ oRate_control, latch the target and go to WAIT_EDGE. A request whose target equals oRate_control is ignored.
  - WAIT_EDGE: a new request overwrites the target (last wins). If the new target equals oRate_control, return to IDLE with no change. On a detected fall, load the target into oRate_control and go to IDLE.
  - Request and fall in the same cycle: the fall applies the *old* target. The new request is then evaluated in IDLE on the following cycle; it is not lost and is registered into a one-deep hold.
- oBusy = 1 exactly while in WAIT_EDGE.
- If iDivClk stops toggling, WAIT_EDGE is held indefinitely. No timeout.

## Timing
- Reset values: oRate_control=00, oBusy=0, oCmdErr=0, state=IDLE, sync flops and button register=0, sweep disabled, sweep counter=0.
- Request accepted at edge k → oBusy=1 after edge k.
- iDivClk first sampled low by s1 at edge n:
  - fall detected in the cycle after edge n+1;
  - oRate_control updates and oBusy clears at edge n+2.
- oCmdErr: high for exactly the cycle after the edge that sampled iRxValid.
- Reset asserted mid-change: the pending target is discarded and all outputs return to their reset values immediately.

## Configuration
- BLINK_AUTO_SWEEP_EN defined:
  - Byte 'a' toggles sweep mode.
  - While enabled, a 32-bit counter counts 0..CLOCKFREQ*SWEEP_SEC-1. On wrap it raises a next request, which is the lowest priority.
  - '0'/'1'/'2' disable sweep and clear the counter. 'n' and the button leave sweep unaffected.
  - Toggling sweep on starts the counter from 0.
- BLINK_AUTO_SWEEP_EN undefined: no counter logic; 'a' is an unrecognised byte and pulses oCmdErr.

## Test plan
- Reset: hold iRSt_n=0 with iDivClk toggling → oRate_control=00, oBusy=0, oCmdErr=0 throughout; after release, no false fall is detected.
- 0x32 with iDivClk=1 → oBusy=1 on the next cycle; oRate_control stays 00 until iDivClk falls; it becomes 10 two edges after s1 samples low, and oBusy clears on that same edge.
- From 00: 0x31, then 0x30 before any fall → oBusy returns to 0; oRate_control remains 00 across subsequent falls.
- 0x41 → oCmdErr high for 1 cycle; oRate_control and oBusy unchanged.
- From 01: button rising edge and 'n' in the same cycle → a single next request; target 10 after the fall, never 00.
- BLINK_AUTO_SWEEP_EN with CLOCKFREQ=100, SWEEP_SEC=2, iDivClk toggling every 7 cycles: after 'a', next requests occur every 200 cycles (00→01→10→00); sending '1' stops the sweep.

Source files
------------

// File: rtl/blink_rate_ctrl.sv
// Rate controller for the LED blink divider: decodes UART/button rate requests and
// applies them on a falling edge of the divider output. Optional sweep: BLINK_AUTO_SWEEP_EN.
module blink_rate_ctrl #(
    parameter int unsigned CLOCKFREQ = 100_000_000,
    parameter int unsigned SWEEP_SEC = 5
) (
    input  logic       iClk,
    input  logic       iRSt_n,
    input  logic [7:0] iRxData,
    input  logic       iRxValid,
    input  logic       iBtnNext,
    input  logic       iDivClk,
    output logic [1:0] oRate_control,
    output logic       oBusy,
    output logic       oCmdErr
);

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_EDGE = 1'b1
    } state_t;

    localparam logic [7:0]  BYTE_RATE0 = 8'h30;
    localparam logic [7:0]  BYTE_RATE1 = 8'h31;
    localparam logic [7:0]  BYTE_RATE2 = 8'h32;
    localparam logic [7:0]  BYTE_NEXT  = 8'h6E;
    localparam logic [7:0]  BYTE_SWEEP = 8'h61;
    localparam logic [63:0] SWEEP_CYCLES = 64'(CLOCKFREQ) * 64'(SWEEP_SEC);

    // The sweep counter is 32 bits wide, so the interval must fit in it.
    if (SWEEP_CYCLES == 64'd0 || SWEEP_CYCLES > 64'h1_0000_0000) begin : g_bad_cfg
        $error("blink_rate_ctrl: CLOCKFREQ*SWEEP_SEC must be in 1..2^32");
    end

    function automatic logic [1:0] next_rate(input logic [1:0] rate);
        case (rate)
            2'b00:   next_rate = 2'b01;
            2'b01:   next_rate = 2'b10;
            default: next_rate = 2'b00;
        endcase
    endfunction

    state_t     r_state;
    logic [1:0] r_rate;
    logic [1:0] r_target;
    logic       r_hold_vld;
    logic [1:0] r_hold_tgt;
    logic       r_btn_q;
    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic       r_cmd_err;

    state_t     w_state_nxt;
    logic [1:0] w_rate_nxt;
    logic [1:0] w_target_nxt;
    logic       w_hold_vld_nxt;
    logic [1:0] w_hold_tgt_nxt;

    logic       w_is_digit;
    logic       w_is_next;
    logic       w_is_sweep;
    logic       w_bad_byte;
    logic       w_btn_rise;
    logic       w_fall;
    logic       w_sweep_tick;
    logic [1:0] w_pending;
    logic       w_req;
    logic [1:0] w_req_tgt;
    logic       w_idle_vld;
    logic [1:0] w_idle_tgt;

    assign w_is_digit = iRxValid && (iRxData == BYTE_RATE0 || iRxData == BYTE_RATE1 ||
                                     iRxData == BYTE_RATE2);
    assign w_is_next  = iRxValid && (iRxData == BYTE_NEXT);
    assign w_bad_byte = iRxValid && !(w_is_digit || w_is_next || w_is_sweep);
    assign w_btn_rise = iBtnNext && !r_btn_q;
    assign w_fall     = r_s3 && !r_s2;

`ifdef BLINK_AUTO_SWEEP_EN
    localparam logic [31:0] SWEEP_LAST = 32'(SWEEP_CYCLES - 64'd1);

    logic        r_sweep_en;
    logic [31:0] r_sweep_cnt;

    assign w_is_sweep   = iRxValid && (iRxData == BYTE_SWEEP);
    assign w_sweep_tick = r_sweep_en && (r_sweep_cnt == SWEEP_LAST);

    // An explicit rate byte cancels the sweep; toggling always restarts the interval.
    always_ff @(posedge iClk or negedge iRSt_n) begin
        if (!iRSt_n) begin
            r_sweep_en  <= 1'b0;
            r_sweep_cnt <= '0;
        end else if (w_is_digit) begin
            r_sweep_en  <= 1'b0;
            r_sweep_cnt <= '0;
        end else if (w_is_sweep) begin
            r_sweep_en  <= !r_sweep_en;
            r_sweep_cnt <= '0;
        end else if (r_sweep_en) begin
            r_sweep_cnt <= w_sweep_tick ? '0 : r_sweep_cnt + 32'd1;
        end
    end
`else
    assign w_is_sweep   = 1'b0;
    assign w_sweep_tick = 1'b0;
`endif

    // "Next" steps from whatever target is still waiting to be applied.
    assign w_pending = (r_state == ST_WAIT_EDGE) ? r_target :
                       r_hold_vld                ? r_hold_tgt : r_rate;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_req     = 1'b0;
        w_req_tgt = r_rate;
        if (w_is_digit) begin
            w_req     = 1'b1;
            w_req_tgt = iRxData[1:0];
        end else if (w_is_next || w_btn_rise || w_sweep_tick) begin
            w_req     = 1'b1;
            w_req_tgt = next_rate(w_pending);
        end
    end

    // A fresh request in IDLE supersedes anything parked in the hold register.
    assign w_idle_vld = w_req || r_hold_vld;
    assign w_idle_tgt = w_req ? w_req_tgt : r_hold_tgt;

    always_comb begin
        w_state_nxt    = r_state;
        w_rate_nxt     = r_rate;
        w_target_nxt   = r_target;
        w_hold_vld_nxt = 1'b0;
        w_hold_tgt_nxt = r_hold_tgt;
        case (r_state)
            ST_IDLE: begin
                if (w_idle_vld && (w_idle_tgt != r_rate)) begin
                    w_target_nxt = w_idle_tgt;
                    w_state_nxt  = ST_WAIT_EDGE;
                end
            end
            ST_WAIT_EDGE: begin
                if (w_fall) begin
                    w_rate_nxt  = r_target;
                    w_state_nxt = ST_IDLE;
                    if (w_req) begin
                        w_hold_vld_nxt = 1'b1;
                        w_hold_tgt_nxt = w_req_tgt;
                    end
                end else if (w_req) begin
                    w_target_nxt = w_req_tgt;
                    if (w_req_tgt == r_rate) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRSt_n) begin
        if (!iRSt_n) begin
            r_state    <= ST_IDLE;
            r_rate     <= 2'b00;
            r_target   <= 2'b00;
            r_hold_vld <= 1'b0;
            r_hold_tgt <= 2'b00;
            r_btn_q    <= 1'b0;
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_state    <= w_state_nxt;
            r_rate     <= w_rate_nxt;
            r_target   <= w_target_nxt;
            r_hold_vld <= w_hold_vld_nxt;
            r_hold_tgt <= w_hold_tgt_nxt;
            r_btn_q    <= iBtnNext;
            r_s1       <= iDivClk;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_cmd_err  <= w_bad_byte;
        end
    end

    assign oRate_control = r_rate;
    assign oBusy         = (r_state == ST_WAIT_EDGE);
    assign oCmdErr       = r_cmd_err;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Directed self-checking bench for blink_rate_ctrl; the sweep section runs only
// when BLINK_AUTO_SWEEP_EN is defined.
module tb_blink_rate_ctrl;

    logic       iClk = 1'b0;
    logic       iRSt_n = 1'b0;
    logic [7:0] iRxData = 8'h00;
    logic       iRxValid = 1'b0;
    logic       iBtnNext = 1'b0;
    logic       iDivClk = 1'b1;
    logic [1:0] oRate_control;
    logic       oBusy;
    logic       oCmdErr;

    int n_checks = 0;
    int n_pass   = 0;

    blink_rate_ctrl #(
        .CLOCKFREQ(100),
        .SWEEP_SEC(2)
    ) dut (
        .iClk         (iClk),
        .iRSt_n       (iRSt_n),
        .iRxData      (iRxData),
        .iRxValid     (iRxValid),
        .iBtnNext     (iBtnNext),
        .iDivClk      (iDivClk),
        .oRate_control(oRate_control),
        .oBusy        (oBusy),
        .oCmdErr      (oCmdErr)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        iRxData  = b;
        iRxValid = 1'b1;
        tick();
        iRxValid = 1'b0;
    endtask

    // High for three edges, then low: the new rate lands on the sixth edge.
    task automatic do_fall();
        iDivClk = 1'b1;
        repeat (3) tick();
        iDivClk = 1'b0;
        repeat (3) tick();
        iDivClk = 1'b1;
    endtask

    initial begin
        // Reset held while the divider toggles.
        for (int i = 0; i < 4; i++) begin
            iDivClk = ~iDivClk;
            tick();
            check("rst_rate", 8'(oRate_control), 8'h00);
            check("rst_busy", 8'(oBusy), 8'h00);
            check("rst_err", 8'(oCmdErr), 8'h00);
        end
        iDivClk = 1'b1;
        iRSt_n  = 1'b1;

        // '2' with divider high: pending until it falls, no false fall after reset.
        send(8'h32);
        check("r2_busy", 8'(oBusy), 8'h01);
        check("r2_rate", 8'(oRate_control), 8'h00);
        repeat (5) tick();
        check("r2_hold_busy", 8'(oBusy), 8'h01);
        check("r2_hold_rate", 8'(oRate_control), 8'h00);
        iDivClk = 1'b0;
        tick();
        tick();
        check("r2_pre_rate", 8'(oRate_control), 8'h00);
        check("r2_pre_busy", 8'(oBusy), 8'h01);
        tick();
        check("r2_rate_done", 8'(oRate_control), 8'h02);
        check("r2_busy_done", 8'(oBusy), 8'h00);
        iDivClk = 1'b1;

        send(8'h30);
        do_fall();
        check("r0_rate", 8'(oRate_control), 8'h00);

        // '1' then '0' before any fall cancels the change.
        send(8'h31);
        check("cancel_busy1", 8'(oBusy), 8'h01);
        send(8'h30);
        check("cancel_busy0", 8'(oBusy), 8'h00);
        do_fall();
        check("cancel_rate", 8'(oRate_control), 8'h00);
        check("cancel_busy", 8'(oBusy), 8'h00);

        // Unrecognised byte.
        send(8'h41);
        check("err_pulse", 8'(oCmdErr), 8'h01);
        check("err_rate", 8'(oRate_control), 8'h00);
        check("err_busy", 8'(oBusy), 8'h00);
        tick();
        check("err_clear", 8'(oCmdErr), 8'h00);

        // Button edge and 'n' together from 01: one request only.
        send(8'h31);
        do_fall();
        check("to01_rate", 8'(oRate_control), 8'h01);
        iBtnNext = 1'b1;
        send(8'h6E);
        check("dual_busy", 8'(oBusy), 8'h01);
        do_fall();
        check("dual_rate", 8'(oRate_control), 8'h02);
        check("dual_busy_done", 8'(oBusy), 8'h00);
        iBtnNext = 1'b0;
        tick();

        // Button alone: 10 -> 00.
        iBtnNext = 1'b1;
        tick();
        check("btn_busy", 8'(oBusy), 8'h01);
        iBtnNext = 1'b0;
        do_fall();
        check("btn_rate", 8'(oRate_control), 8'h00);

        // 'n' while pending steps from the pending target: 01 -> 10.
        send(8'h31);
        send(8'h6E);
        check("nxt_pend_busy", 8'(oBusy), 8'h01);
        do_fall();
        check("nxt_pend_rate", 8'(oRate_control), 8'h02);

        // Request in the same cycle as the fall: old target applied, new one held.
        send(8'h30);
        repeat (3) tick();
        iDivClk = 1'b0;
        tick();
        tick();
        send(8'h31);
        check("same_rate_old", 8'(oRate_control), 8'h00);
        check("same_idle", 8'(oBusy), 8'h00);
        tick();
        check("same_hold_busy", 8'(oBusy), 8'h01);
        check("same_hold_rate", 8'(oRate_control), 8'h00);
        do_fall();
        check("same_new_rate", 8'(oRate_control), 8'h01);
        check("same_busy_done", 8'(oBusy), 8'h00);

`ifdef BLINK_AUTO_SWEEP_EN
        // Sweep every 200 cycles from rate 01.
        send(8'h61);
        check("sw_no_err", 8'(oCmdErr), 8'h00);
        repeat (199) tick();
        check("sw1_before", 8'(oBusy), 8'h00);
        tick();
        check("sw1_busy", 8'(oBusy), 8'h01);
        do_fall();
        check("sw1_rate", 8'(oRate_control), 8'h02);
        repeat (193) tick();
        check("sw2_before", 8'(oBusy), 8'h00);
        tick();
        check("sw2_busy", 8'(oBusy), 8'h01);
        do_fall();
        check("sw2_rate", 8'(oRate_control), 8'h00);
        send(8'h31);
        do_fall();
        check("sw_stop_rate", 8'(oRate_control), 8'h01);
        repeat (300) tick();
        check("sw_off_busy", 8'(oBusy), 8'h00);
        check("sw_off_rate", 8'(oRate_control), 8'h01);
`else
        send(8'h61);
        check("a_err", 8'(oCmdErr), 8'h01);
        check("a_busy", 8'(oBusy), 8'h00);
        check("a_rate", 8'(oRate_control), 8'h01);
`endif

        // Reset in the middle of a pending change.
        send(8'h32);
        check("mid_busy", 8'(oBusy), 8'h01);
        #1 iRSt_n = 1'b0;
        #1;
        check("mid_rst_rate", 8'(oRate_control), 8'h00);
        check("mid_rst_busy", 8'(oBusy), 8'h00);
        check("mid_rst_err", 8'(oCmdErr), 8'h00);
        tick();
        iRSt_n = 1'b1;
        do_fall();
        check("post_rst_rate", 8'(oRate_control), 8'h00);
        check("post_rst_busy", 8'(oBusy), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
